// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad PMOD front end: button bit positions within a
// pad word, the absent-pad code and the default auto-repeat set.
package gamepad_pkg;

  localparam int unsigned PAD_BITS = 12;

  localparam int unsigned BTN_R      = 0;
  localparam int unsigned BTN_L      = 1;
  localparam int unsigned BTN_X      = 2;
  localparam int unsigned BTN_A      = 3;
  localparam int unsigned BTN_RIGHT  = 4;
  localparam int unsigned BTN_LEFT   = 5;
  localparam int unsigned BTN_DOWN   = 6;
  localparam int unsigned BTN_UP     = 7;
  localparam int unsigned BTN_START  = 8;
  localparam int unsigned BTN_SELECT = 9;
  localparam int unsigned BTN_Y      = 10;
  localparam int unsigned BTN_B      = 11;

  localparam logic [PAD_BITS-1:0] REPEAT_MASK_DEFAULT = 12'h0F0;
  localparam logic [PAD_BITS-1:0] ABSENT_CODE         = 12'hFFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gamepad_btn_event.sv
// Per-pad button decoder: registered levels, press/release pulses, presence and
// frame-counted auto-repeat for the masked buttons.
module gamepad_btn_event
  import gamepad_pkg::*;
#(
  parameter logic [PAD_BITS-1:0] REPEAT_MASK  = REPEAT_MASK_DEFAULT,
  parameter int unsigned         REPEAT_DELAY = 20,
  parameter int unsigned         REPEAT_RATE  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PAD_BITS-1:0] word_i,
  input  logic                accept_i,
  input  logic                timeout_i,
  input  logic                present_i,
  output logic [PAD_BITS-1:0] buttons_o,
  output logic [PAD_BITS-1:0] pressed_o,
  output logic [PAD_BITS-1:0] released_o,
  output logic [PAD_BITS-1:0] repeat_evt_o,
  output logic                present_o
);

  localparam int unsigned CntW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

  logic [PAD_BITS-1:0] lvl_q, lvl_d;
  logic [PAD_BITS-1:0] pressed_q, pressed_d;
  logic [PAD_BITS-1:0] released_q, released_d;
  logic [PAD_BITS-1:0] rep_q, rep_d;
  logic [PAD_BITS-1:0] rpt_on_q, rpt_on_d;
  logic                present_q, present_d;
  logic                regain_q, regain_d;
  logic [CntW-1:0]     cnt_q [PAD_BITS];
  logic [CntW-1:0]     cnt_d [PAD_BITS];
  logic [PAD_BITS-1:0] new_lvl, base, held;
  logic [CntW-1:0]     tgt;

  always_comb begin
    lvl_d      = lvl_q;
    present_d  = present_q;
    regain_d   = regain_q;
    rpt_on_d   = rpt_on_q;
    cnt_d      = cnt_q;
    pressed_d  = '0;
    released_d = '0;
    rep_d      = '0;
    tgt        = '0;
    new_lvl    = present_i ? word_i : '0;
    // A pad returning after absence or timeout takes its new word as baseline;
    // out of reset the baseline is all-released.
    base       = present_q ? lvl_q : (regain_q ? new_lvl : '0);
    held       = new_lvl & lvl_q;
    if (timeout_i) begin
      lvl_d      = '0;
      present_d  = 1'b0;
      regain_d   = 1'b1;
      released_d = lvl_q;
      rpt_on_d   = '0;
      for (int i = 0; i < PAD_BITS; i++) cnt_d[i] = '0;
    end else if (accept_i) begin
      lvl_d      = new_lvl;
      present_d  = present_i;
      regain_d   = ~present_i;
      pressed_d  = new_lvl & ~base;
      released_d = lvl_q & ~new_lvl;
      for (int i = 0; i < PAD_BITS; i++) begin
        tgt = rpt_on_q[i] ? CntW'(REPEAT_RATE) : CntW'(REPEAT_DELAY);
        if (pressed_d[i]) begin
          cnt_d[i]    = '0;
          rpt_on_d[i] = 1'b0;
          rep_d[i]    = 1'b1;
        end else if (held[i]) begin
          if (cnt_q[i] + CntW'(1) == tgt) begin
            cnt_d[i]    = '0;
            rpt_on_d[i] = 1'b1;
            rep_d[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end else begin
          cnt_d[i]    = '0;
          rpt_on_d[i] = 1'b0;
        end
      end
      rep_d = rep_d & REPEAT_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q      <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      rep_q      <= '0;
      rpt_on_q   <= '0;
      present_q  <= 1'b0;
      regain_q   <= 1'b0;
      cnt_q      <= '{default: '0};
    end else begin
      lvl_q      <= lvl_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      rep_q      <= rep_d;
      rpt_on_q   <= rpt_on_d;
      present_q  <= present_d;
      regain_q   <= regain_d;
      cnt_q      <= cnt_d;
    end
  end

  assign buttons_o    = lvl_q;
  assign pressed_o    = pressed_q;
  assign released_o   = released_q;
  assign repeat_evt_o = rep_q;
  assign present_o    = present_q;

endmodule

// File: rtl/gamepad_pmod_input.sv
// Multi-pad PMOD gamepad front end: synchronises the serial chain, frames and
// validates it, tracks staleness and hands each pad word to its event decoder.
module gamepad_pmod_input
  import gamepad_pkg::*;
#(
  parameter int unsigned         NUM_PADS       = 2,
  parameter int unsigned         SYNC_STAGES    = 2,
  parameter logic [PAD_BITS-1:0] REPEAT_MASK    = REPEAT_MASK_DEFAULT,
  parameter int unsigned         REPEAT_DELAY   = 20,
  parameter int unsigned         REPEAT_RATE    = 6,
  parameter int unsigned         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pmod_data_i,
  input  logic                         pmod_clk_i,
  input  logic                         pmod_latch_i,
  output logic [NUM_PADS*PAD_BITS-1:0] buttons_o,
  output logic [NUM_PADS*PAD_BITS-1:0] pressed_o,
  output logic [NUM_PADS*PAD_BITS-1:0] released_o,
  output logic [NUM_PADS*PAD_BITS-1:0] repeat_evt_o,
  output logic [NUM_PADS-1:0]          present_o,
  output logic                         stale_o,
  output logic                         frame_strobe_o,
  output logic                         frame_error_o
);

  localparam int unsigned FrameBits = NUM_PADS * PAD_BITS;
  localparam int unsigned CntW      = $clog2(FrameBits + 2);
  localparam int unsigned TmoW      = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] data_sync_q, clk_sync_q, latch_sync_q;
  logic                   clk_prev_q, latch_prev_q;
  logic                   clk_rise, latch_rise;
  logic [FrameBits-1:0]   shift_q, shift_d, capture_q, capture_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_shifted;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic                   accept_q, accept_d;
  logic                   err_q, err_d;
  logic                   timeout_q, timeout_d;
  logic                   stale_q, stale_d;
  logic                   frame_strobe_q, frame_error_q;

  assign clk_rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign latch_rise = latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;

  always_comb begin
    shift_d     = shift_q;
    cnt_shifted = cnt_q;
    if (clk_rise) begin
      shift_d = {shift_q[FrameBits-2:0], data_sync_q[SYNC_STAGES-1]};
      if (cnt_q != CntW'(FrameBits + 1)) cnt_shifted = cnt_q + CntW'(1);
    end
    // A latch in the same cycle as a shift judges the post-shift count.
    accept_d  = latch_rise && (cnt_shifted == CntW'(FrameBits));
    err_d     = latch_rise && !accept_d;
    cnt_d     = latch_rise ? '0 : cnt_shifted;
    capture_d = accept_d ? shift_d : capture_q;
    tmo_d     = accept_d ? '0 :
                (tmo_q == TmoW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TmoW'(1);
    timeout_d = !accept_d && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    stale_d   = timeout_q ? 1'b1 : (accept_q ? 1'b0 : stale_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_sync_q    <= '0;
      clk_sync_q     <= '0;
      latch_sync_q   <= '0;
      clk_prev_q     <= 1'b0;
      latch_prev_q   <= 1'b0;
      shift_q        <= '1;
      capture_q      <= '1;
      cnt_q          <= '0;
      tmo_q          <= '0;
      accept_q       <= 1'b0;
      err_q          <= 1'b0;
      timeout_q      <= 1'b0;
      stale_q        <= 1'b1;
      frame_strobe_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      data_sync_q    <= {data_sync_q[SYNC_STAGES-2:0], pmod_data_i};
      clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], pmod_clk_i};
      latch_sync_q   <= {latch_sync_q[SYNC_STAGES-2:0], pmod_latch_i};
      clk_prev_q     <= clk_sync_q[SYNC_STAGES-1];
      latch_prev_q   <= latch_sync_q[SYNC_STAGES-1];
      shift_q        <= shift_d;
      capture_q      <= capture_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      accept_q       <= accept_d;
      err_q          <= err_d;
      timeout_q      <= timeout_d;
      stale_q        <= stale_d;
      frame_strobe_q <= accept_q;
      frame_error_q  <= err_q;
    end
  end

  assign stale_o        = stale_q;
  assign frame_strobe_o = frame_strobe_q;
  assign frame_error_o  = frame_error_q;

  // Pad NUM_PADS-1 is shifted in first, so it ends up in the top slice.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [PAD_BITS-1:0] pad_word;
    assign pad_word = capture_q[p*PAD_BITS +: PAD_BITS];

    gamepad_btn_event #(
      .REPEAT_MASK (REPEAT_MASK),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_btn_event (
      .clk         (clk),
      .rst_n       (rst_n),
      .word_i      (pad_word),
      .accept_i    (accept_q),
      .timeout_i   (timeout_q),
      .present_i   (pad_word != ABSENT_CODE),
      .buttons_o   (buttons_o[p*PAD_BITS +: PAD_BITS]),
      .pressed_o   (pressed_o[p*PAD_BITS +: PAD_BITS]),
      .released_o  (released_o[p*PAD_BITS +: PAD_BITS]),
      .repeat_evt_o(repeat_evt_o[p*PAD_BITS +: PAD_BITS]),
      .present_o   (present_o[p])
    );
  end

endmodule

// File: tb/tb_gamepad_pmod_input.sv
// Scoreboard bench for gamepad_pmod_input: frames are driven on the PMOD pins and a
// monitor compares every strobe, error and stale event against queued expectations.
module tb_gamepad_pmod_input;

  localparam int unsigned Tmo = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pd = 1'b0, pc = 1'b0, pl = 1'b0;
  logic [23:0] buttons, pressed, released, rep;
  logic [1:0]  present;
  logic        stale, strobe, ferr;

  gamepad_pmod_input #(
    .NUM_PADS      (2),
    .SYNC_STAGES   (2),
    .REPEAT_MASK   (12'h0F0),
    .REPEAT_DELAY  (20),
    .REPEAT_RATE   (6),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmod_data_i   (pd),
    .pmod_clk_i    (pc),
    .pmod_latch_i  (pl),
    .buttons_o     (buttons),
    .pressed_o     (pressed),
    .released_o    (released),
    .repeat_evt_o  (rep),
    .present_o     (present),
    .stale_o       (stale),
    .frame_strobe_o(strobe),
    .frame_error_o (ferr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        tmo;
    logic [23:0] btn;
    logic [23:0] pr;
    logic [23:0] rl;
    logic [23:0] rp;
    logic [1:0]  ps;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_strobe = 0;
  int   bound_fail = 0;
  bit   end_req = 1'b0;
  logic stale_prev = 1'b1;

  function automatic exp_t mk(input logic err, input logic tmo, input logic [23:0] btn,
                              input logic [23:0] pr, input logic [23:0] rl,
                              input logic [23:0] rp, input logic [1:0] ps, input logic st);
    exp_t e;
    e.err = err; e.tmo = tmo; e.btn = btn; e.pr = pr; e.rl = rl; e.rp = rp; e.ps = ps;
    e.st = st;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising clk edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cyc > 20000) begin
      total++;
      bad++;
      $display("FAIL watchdog: cycle %0d, required finish before 20000", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (end_req) begin
      check("scoreboard_empty", 32'(sb.size()), 0);
      check("wait_bound", 32'(bound_fail), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (!rst_n) begin
      check("rst_levels", {8'h0, buttons}, 0);
      check("rst_pulses", {8'h0, pressed | released | rep}, 0);
      check("rst_flags", {27'h0, present, stale, strobe, ferr}, 32'h4);
      stale_prev = stale;
    end else begin
      if (strobe || ferr || (stale && !stale_prev)) begin
        if (sb.size() == 0) begin
          check("spurious_event", {29'h0, strobe, ferr, stale}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe", {31'h0, strobe}, {31'h0, !e.err && !e.tmo});
          check("frame_error", {31'h0, ferr}, {31'h0, e.err});
          check("buttons", {8'h0, buttons}, {8'h0, e.btn});
          check("pressed", {8'h0, pressed}, {8'h0, e.pr});
          check("released", {8'h0, released}, {8'h0, e.rl});
          check("repeat_evt", {8'h0, rep}, {8'h0, e.rp});
          check("present", {30'h0, present}, {30'h0, e.ps});
          check("stale", {31'h0, stale}, {31'h0, e.st});
          if (e.tmo) check("timeout_latency", 32'(cyc - last_strobe), Tmo);
        end
        if (strobe) last_strobe = cyc;
      end else begin
        check("quiet_pulses", {8'h0, pressed | released | rep}, 0);
      end
      stale_prev = stale;
    end
  end

  task automatic send_bits(input logic [23:0] f, input int n, input bit merge);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pd = f[23-i];
      pc = 1'b0;
      @(negedge clk);
      pc = 1'b1;
      if (merge && i == n - 1) pl = 1'b1;
    end
    @(negedge clk);
    pc = 1'b0;
    if (merge) begin
      pl = 1'b0;
    end else begin
      @(negedge clk);
      pl = 1'b1;
      @(negedge clk);
      pl = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) bound_fail++;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First frame out of reset: right (bit 4) pressed on pad 0, pad 1 absent.
    sb.push_back(mk(0, 0, 24'h000010, 24'h000010, 0, 24'h000010, 2'b01, 0));
    send_bits(24'hFFF010, 24, 0);

    // Hold for frames 1..29: repeats at frame 20 and then 26.
    for (int n = 1; n < 30; n++) begin
      sb.push_back(mk(0, 0, 24'h000010, 0, 0, (n == 20 || n == 26) ? 24'h000010 : 24'h0,
                      2'b01, 0));
      send_bits(24'hFFF010, 24, 0);
    end

    // Pad 1 appears with b held: no press pulse on presence gain.
    sb.push_back(mk(0, 0, 24'h800010, 0, 0, 0, 2'b11, 0));
    send_bits(24'h800010, 24, 0);

    // Last shift and latch land in the same cycle.
    sb.push_back(mk(0, 0, 24'h800010, 0, 0, 0, 2'b11, 0));
    send_bits(24'h800010, 24, 1);

    // Short frame is discarded, then the chain goes quiet until timeout.
    sb.push_back(mk(1, 0, 24'h800010, 0, 0, 0, 2'b11, 0));
    send_bits(24'h000000, 23, 0);
    sb.push_back(mk(0, 1, 24'h0, 0, 24'h800010, 0, 2'b00, 1));
    wait_idle(300);

    // Recovery after stale is a presence gain for both pads.
    sb.push_back(mk(0, 0, 24'h800020, 0, 0, 0, 2'b11, 0));
    send_bits(24'h800020, 24, 0);

    // Pad 1 drops out; pad 0 swaps left for down+r (only down is repeat-masked).
    sb.push_back(mk(0, 0, 24'h000041, 24'h000041, 24'h800020, 24'h000040, 2'b01, 0));
    send_bits(24'hFFF041, 24, 0);
    wait_idle(50);

    // Reset in the middle of a frame, then a clean frame.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pd = 1'b1;
      pc = 1'b0;
      @(negedge clk);
      pc = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    pc = 1'b0;
    pd = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(mk(0, 0, 24'h000010, 24'h000010, 0, 24'h000010, 2'b01, 0));
    send_bits(24'hFFF010, 24, 0);
    wait_idle(50);

    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

endmodule
